// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state encoding and bus geometry for the Avalon memory responder
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} resp_state_t;
  localparam int BYTE_LANES = 4;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/mem_byte_merge.sv
// mem_byte_merge: builds the stored word from the old word and the enabled lanes of writedata
module mem_byte_merge
  import mem_resp_pkg::*;
(
  input  logic [31:0]           old_word,
  input  logic [31:0]           wdata,
  input  logic [BYTE_LANES-1:0] be,
  output logic [31:0]           new_word
);
  // each enabled lane takes the store byte, disabled lanes keep the old byte
  always_comb begin
    new_word = old_word;
    for (int i = 0; i < BYTE_LANES; i++)
      new_word[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
  end
endmodule

// File: rtl/avalon_mem_responder.sv
// avalon_mem_responder: word RAM window serving the Avalon read/write/waitrequest handshake
module avalon_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int          WAIT_CYCLES = 1,
  parameter              INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  Rst_n,
  input  logic [31:0]           address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic [BYTE_LANES-1:0] byteenable,
  output logic                  waitrequest,
  output logic [31:0]           readdata,
  output logic                  err
);
  localparam int          CW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [32:0] SPAN = 33'(WORD_BYTES) << ADDR_W;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  resp_state_t           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic                  wr_q, wr_d, fault_q, fault_d;
  logic [31:0]           wdata_q, wdata_d, readdata_q, readdata_d;
  logic [BYTE_LANES-1:0] be_q, be_d;
  logic [31:0]           offset, old_word, new_word;
  logic                  req, access, mem_we;

  assign req         = read | write;
  assign offset      = address - BASE_ADDR;
  assign old_word    = mem[idx_q];
  assign access      = (state_q == BUSY) && req && (cnt_q == '0);
  assign mem_we      = access && wr_q && !fault_q;
  assign waitrequest = !Rst_n || ((state_q == IDLE) ? req : (state_q != DONE));
  assign err         = (state_q == DONE) && fault_q;
  assign readdata    = readdata_q;

  mem_byte_merge u_merge (
    .old_word (old_word),
    .wdata    (wdata_q),
    .be       (be_q),
    .new_word (new_word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wr_d       = wr_q;
    fault_d    = fault_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    readdata_d = readdata_q;
    if (state_q == IDLE && req) begin
      state_d = BUSY;
      cnt_d   = CW'(WAIT_CYCLES);
      idx_d   = offset[ADDR_W+1:2];
      wr_d    = write;
      wdata_d = writedata;
      be_d    = byteenable;
      fault_d = (address[1:0] != 2'b00) || (address < BASE_ADDR) ||
                ({1'b0, offset} >= SPAN) || (read && write);
    end else if (state_q == BUSY) begin
      state_d = !req ? IDLE : ((cnt_q == '0) ? DONE : BUSY);
      cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    if (access && !wr_q) readdata_d = fault_q ? 32'h0 : old_word;
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      fault_q    <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wr_q       <= wr_d;
      fault_q    <= fault_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      readdata_q <= readdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= new_word;
  end
endmodule

// File: tb/tb_avalon_mem_responder.sv
// tb_avalon_mem_responder: directed transfers checked by a scoreboard monitor
module tb_avalon_mem_responder;
  localparam logic [31:0] B = 32'hBFC0_0000;

  typedef struct {
    string       nm;
    logic        chk_rd;
    logic [31:0] rd;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [31:0] address = '0, writedata = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [3:0]  byteenable = '0;
  logic        waitrequest, err;
  logic [31:0] readdata;

  logic [31:0] address0 = B, writedata0 = '0;
  logic        read0 = 1'b0, write0 = 1'b0;
  logic [3:0]  byteenable0 = '0;
  logic        waitrequest0, err0;
  logic [31:0] readdata0;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  avalon_mem_responder #(.ADDR_W(10), .BASE_ADDR(B), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .Rst_n(Rst_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
    .readdata(readdata), .err(err)
  );

  avalon_mem_responder #(.ADDR_W(10), .BASE_ADDR(B), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .Rst_n(Rst_n), .address(address0), .read(read0), .write(write0),
    .writedata(writedata0), .byteenable(byteenable0), .waitrequest(waitrequest0),
    .readdata(readdata0), .err(err0)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: every completing cycle of a held request is matched against the scoreboard
  always @(negedge clk) begin
    if (Rst_n && !waitrequest && (read || write)) begin
      if (sb.size() == 0) begin
        check("unexpected completion", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check({x.nm, " err"}, {31'd0, err}, {31'd0, x.e});
        if (x.chk_rd) check({x.nm, " readdata"}, readdata, x.rd);
      end
    end
  end

  task automatic xfer(input string nm, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be, input logic chk,
                      input logic [31:0] exp_rd, input logic exp_err, output int hi);
    sb.push_back('{nm, chk, exp_rd, exp_err});
    @(posedge clk); #1;
    read = rd; write = wr; address = a; writedata = d; byteenable = be;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!waitrequest) break;
      hi++;
    end
    if (hi >= 20) check({nm, " timeout"}, 32'd1, 32'd0);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    int hi;
    #2;
    check("reset waitrequest", {31'd0, waitrequest}, 32'd1);
    check("reset readdata", readdata, 32'h0);
    check("reset err", {31'd0, err}, 32'd0);
    @(negedge clk); Rst_n = 1'b1;

    xfer("preload w0", 0, 1, B,     32'h2402_0005, 4'hF, 0, 0, 0, hi);
    xfer("preload w1", 0, 1, B + 4, 32'h1122_3344, 4'hF, 0, 0, 0, hi);
    xfer("read w0", 1, 0, B, 0, 4'h0, 1, 32'h2402_0005, 0, hi);
    check("read wait cycles", hi, 32'd3);
    xfer("merge write", 0, 1, B + 4, 32'hDEAD_BEEF, 4'b0101, 0, 0, 0, hi);
    check("write wait cycles", hi, 32'd3);
    xfer("read merged", 1, 0, B + 4, 0, 4'h0, 1, 32'h11AD_33EF, 0, hi);
    xfer("misaligned read", 1, 0, B + 2, 0, 4'h0, 1, 32'h0, 1, hi);
    xfer("misaligned write", 0, 1, B + 6, 32'hFFFF_FFFF, 4'hF, 0, 0, 1, hi);
    xfer("reread w1", 1, 0, B + 4, 0, 4'h0, 1, 32'h11AD_33EF, 0, hi);
    xfer("out of range write", 0, 1, B + 32'h1000, 32'h0, 4'hF, 0, 0, 1, hi);
    xfer("below base read", 1, 0, B - 4, 0, 4'h0, 1, 32'h0, 1, hi);
    xfer("reread w0", 1, 0, B, 0, 4'h0, 1, 32'h2402_0005, 0, hi);
    xfer("top word write", 0, 1, B + 32'hFFC, 32'hCAFE_F00D, 4'hF, 0, 0, 0, hi);
    xfer("top word read", 1, 0, B + 32'hFFC, 0, 4'h0, 1, 32'hCAFE_F00D, 0, hi);
    xfer("w0 after top", 1, 0, B, 0, 4'h0, 1, 32'h2402_0005, 0, hi);
    xfer("read and write", 1, 1, B, 32'h0, 4'hF, 1, 32'h2402_0005, 1, hi);
    xfer("zero be write", 0, 1, B, 32'h0, 4'h0, 0, 0, 0, hi);
    xfer("w0 unchanged", 1, 0, B, 0, 4'h0, 1, 32'h2402_0005, 0, hi);

    @(posedge clk); #1;
    read = 1'b1; address = B + 4;
    @(negedge clk);
    check("abort idle wait", {31'd0, waitrequest}, 32'd1);
    @(posedge clk); #1;
    read = 1'b0;
    @(negedge clk);
    check("abort busy wait", {31'd0, waitrequest}, 32'd1);
    check("abort busy err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("abort back to idle", {31'd0, waitrequest}, 32'd0);
    check("abort no err", {31'd0, err}, 32'd0);
    xfer("after abort", 1, 0, B + 4, 0, 4'h0, 1, 32'h11AD_33EF, 0, hi);
    check("after abort wait", hi, 32'd3);

    @(posedge clk); #1;
    write = 1'b1; address = B + 4; writedata = 32'h5555_5555; byteenable = 4'hF;
    @(posedge clk); #1;
    Rst_n = 1'b0; write = 1'b0;
    #1;
    check("mid reset waitrequest", {31'd0, waitrequest}, 32'd1);
    check("mid reset readdata", readdata, 32'h0);
    check("mid reset err", {31'd0, err}, 32'd0);
    @(negedge clk); @(negedge clk); Rst_n = 1'b1;
    xfer("word after reset", 1, 0, B + 4, 0, 4'h0, 1, 32'h11AD_33EF, 0, hi);

    @(posedge clk); #1;
    read0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("wait0 pattern %0d", i), {31'd0, waitrequest0}, (i % 3 == 2) ? 32'd0 : 32'd1);
    end
    read0 = 1'b0;

    repeat (2) @(posedge clk);
    check("scoreboard drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
